// File: rtl/sipo_frame_rx.sv
// Serial-in / parallel-out frame receiver: sync marks bit 0, WIDTH bits form a word,
// single-entry output buffer with sticky overrun. Optional parity bit under SIPO_FRAME_RX_PARITY_EN.
module sipo_frame_rx #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             din,
   input  logic             din_valid,
   input  logic             sync,
   output logic [WIDTH-1:0] pout,
   output logic             pout_valid,
   input  logic             out_ready,
   output logic             overrun,
   output logic             busy,
`ifdef SIPO_FRAME_RX_PARITY_EN
   output logic             parity_err,
`endif
   output logic [1:0]       dbg_state
);

   localparam int CW = $clog2(WIDTH + 1);

   // Handshake: pout is consumed on any edge where pout_valid and out_ready are both high;
   // pout is held stable while pout_valid=1 and out_ready=0.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1
`ifdef SIPO_FRAME_RX_PARITY_EN
      ,PARITY = 2'd2
`endif
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sh;
   logic [WIDTH-1:0] sh_next;
   logic [WIDTH-1:0] sh_start;
   logic [WIDTH-1:0] word;
   logic             last_bit;
   logic             word_done;
   logic             can_load;

   always_comb begin
      sh_next  = '0;
      sh_start = '0;
      if (MSB_FIRST) begin
         sh_next  = {sh[WIDTH-2:0], din};
         sh_start = {{(WIDTH-1){1'b0}}, din};
      end else begin
         sh_next  = {din, sh[WIDTH-1:1]};
         sh_start = {din, {(WIDTH-1){1'b0}}};
      end
   end

   assign last_bit = (state == SHIFT) && din_valid && !sync && (cnt == CW'(WIDTH - 1));
   assign can_load = !pout_valid || out_ready;

`ifdef SIPO_FRAME_RX_PARITY_EN
   // With parity the data bits are already in sh; the word completes on the parity bit.
   assign word_done = (state == PARITY) && din_valid && !sync;
   assign word      = sh;
`else
   assign word_done = last_bit;
   assign word      = sh_next;
`endif

   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         sh         <= '0;
         pout       <= '0;
         pout_valid <= 1'b0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         if (pout_valid && out_ready)
            pout_valid <= 1'b0;

         if (word_done) begin
            if (can_load) begin
               pout       <= word;
               pout_valid <= 1'b1;
`ifdef SIPO_FRAME_RX_PARITY_EN
               parity_err <= (^sh) ^ din;
`endif
            end else begin
               overrun <= 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (din_valid && sync) begin
                  sh    <= sh_start;
                  cnt   <= CW'(1);
                  state <= SHIFT;
                  busy  <= 1'b1;
               end
            end
            SHIFT: begin
               if (din_valid) begin
                  if (sync) begin
                     sh  <= sh_start;
                     cnt <= CW'(1);
                  end else if (last_bit) begin
                     sh  <= sh_next;
`ifdef SIPO_FRAME_RX_PARITY_EN
                     cnt   <= CW'(WIDTH);
                     state <= PARITY;
`else
                     cnt   <= '0;
                     state <= IDLE;
                     busy  <= 1'b0;
`endif
                  end else begin
                     sh  <= sh_next;
                     cnt <= cnt + CW'(1);
                  end
               end
            end
`ifdef SIPO_FRAME_RX_PARITY_EN
            PARITY: begin
               if (din_valid) begin
                  if (sync) begin
                     sh    <= sh_start;
                     cnt   <= CW'(1);
                     state <= SHIFT;
                  end else begin
                     cnt   <= '0;
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
`endif
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Bench for sipo_frame_rx: MSB-first and LSB-first instances on shared inputs, checked
// against a bit-list reference model; directed frames followed by random traffic.
module tb_sipo_frame_rx;

   localparam int W = 4;
`ifdef SIPO_FRAME_RX_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif

   logic         clk = 1'b0;
   logic         reset, din, din_valid, sync, out_ready;
   logic [W-1:0] pout_m, pout_l;
   logic         pv_m, pv_l, ov_m, ov_l, busy_m, busy_l;
   logic [1:0]   st_m, st_l;
`ifdef SIPO_FRAME_RX_PARITY_EN
   logic         pe_m, pe_l;
`endif

   always #5 clk = ~clk;

   sipo_frame_rx #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .sync(sync),
      .pout(pout_m), .pout_valid(pv_m), .out_ready(out_ready), .overrun(ov_m),
      .busy(busy_m),
`ifdef SIPO_FRAME_RX_PARITY_EN
      .parity_err(pe_m),
`endif
      .dbg_state(st_m));

   sipo_frame_rx #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .sync(sync),
      .pout(pout_l), .pout_valid(pv_l), .out_ready(out_ready), .overrun(ov_l),
      .busy(busy_l),
`ifdef SIPO_FRAME_RX_PARITY_EN
      .parity_err(pe_l),
`endif
      .dbg_state(st_l));

   int n_checks = 0;
   int n_errors = 0;

   // reference model: bits received so far in the current frame, plus output buffer
   logic         exp_q[$];
   bit           in_frame;
   logic [W-1:0] m_pm, m_pl;
   logic         m_valid, m_over, m_perr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic model_edge();
      bit           done;
      logic [W-1:0] wm, wl;
      logic         par;
      if (reset) begin
         exp_q.delete();
         in_frame = 0;
         m_valid = 0; m_over = 0; m_pm = '0; m_pl = '0; m_perr = 0;
         return;
      end
      done = 0;
      if (din_valid) begin
         if (sync) begin
            exp_q.delete();
            exp_q.push_back(din);
            in_frame = 1;
         end else if (in_frame) begin
            exp_q.push_back(din);
            if (exp_q.size() == FL) done = 1;
         end
      end
      if (done) begin
         wm = '0; wl = '0; par = 0;
         for (int i = 0; i < FL; i++) par ^= exp_q[i];
         for (int i = 0; i < W; i++) begin
            wm[W-1-i] = exp_q[i];
            wl[i]     = exp_q[i];
         end
         exp_q.delete();
         in_frame = 0;
         if (!m_valid || out_ready) begin
            m_pm = wm; m_pl = wl; m_valid = 1; m_perr = par;
         end else begin
            m_over = 1;
         end
      end else if (m_valid && out_ready) begin
         m_valid = 0;
      end
   endtask

   task automatic compare_all();
      check("pout_msb", 32'(pout_m), 32'(m_pm));
      check("pout_lsb", 32'(pout_l), 32'(m_pl));
      check("pout_valid_msb", 32'(pv_m), 32'(m_valid));
      check("pout_valid_lsb", 32'(pv_l), 32'(m_valid));
      check("overrun_msb", 32'(ov_m), 32'(m_over));
      check("overrun_lsb", 32'(ov_l), 32'(m_over));
      check("busy_msb", 32'(busy_m), 32'(in_frame));
      check("busy_lsb", 32'(busy_l), 32'(in_frame));
`ifdef SIPO_FRAME_RX_PARITY_EN
      if (m_valid) begin
         check("parity_err_msb", 32'(pe_m), 32'(m_perr));
         check("parity_err_lsb", 32'(pe_l), 32'(m_perr));
      end
`endif
   endtask

   task automatic step(input logic r, input logic v, input logic s, input logic d, input logic rd);
      reset = r; din_valid = v; sync = s; din = d; out_ready = rd;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   // sends a frame of FL bits (bit 0 first) with sync on the first bit
   task automatic send(input logic [15:0] bits, input logic rd);
      for (int i = 0; i < FL; i++) step(0, 1, (i == 0), bits[i], rd);
   endtask

   initial begin
      reset = 1; din = 0; din_valid = 0; sync = 0; out_ready = 0;
      step(1, 0, 0, 0, 1);
      check("reset_pout", 32'(pout_m), 32'h0);
      check("reset_flags", {29'd0, pv_m, ov_m, busy_m}, 32'h0);

`ifndef SIPO_FRAME_RX_PARITY_EN
      // bits 1,1,0,1
      send(16'b1011, 1);
      check("dir_msb_1101", 32'(pout_m), 32'hD);
      check("dir_lsb_1011", 32'(pout_l), 32'hB);
      check("dir_valid", 32'(pv_m), 32'h1);
      step(0, 0, 0, 0, 1);

      // two frames while blocked: 0101 then 1000 (MSB-first sense)
      send(16'b1010, 0);
      send(16'b0001, 0);
      check("ovr_hold_pout", 32'(pout_m), 32'h5);
      check("ovr_flag", 32'(ov_m), 32'h1);
      step(0, 0, 0, 0, 1);
      check("ovr_release", 32'(pv_m), 32'h0);

      // bits 0,1, three idle cycles, 1,1
      step(0, 1, 1, 0, 1);
      step(0, 1, 0, 1, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);
      step(0, 1, 0, 1, 1);
      step(0, 1, 0, 1, 1);
      check("gap_0111", 32'(pout_m), 32'h7);

      // restart after two bits, then new frame 1001
      step(0, 1, 1, 1, 1);
      step(0, 1, 0, 1, 1);
      send(16'b1001, 1);
      check("resync_1001", 32'(pout_m), 32'h9);

      // back-to-back frames, consumer blocked, then reset mid-frame
      send(16'b0110, 0);
      step(0, 1, 1, 1, 0);
      step(0, 1, 0, 0, 0);
      step(1, 1, 0, 1, 0);
      check("rst_mid_all0", {25'd0, pout_m, pv_m, ov_m, busy_m}, 32'h0);
      send(16'b1111, 1);
      check("post_rst_1111", 32'(pout_m), 32'hF);
`else
      send(16'b00101, 1);
      check("par_ok", 32'(pe_m), 32'h0);
      check("par_ok_pout", 32'(pout_m), 32'hA);
      send(16'b10101, 1);
      check("par_bad", 32'(pe_m), 32'h1);
      check("par_bad_pout", 32'(pout_m), 32'hA);
`endif

      for (int c = 0; c < 1500; c++) begin
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 2) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
